// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit that owns the architectural HI/LO pair.
// Optional MULDIV_FAST_MUL_EN: single-cycle mult/multu; divide always stays iterative.
module ex_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] WrData,
    input  logic        HiLoRead,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic        Stall
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           fix_ph_q;
    logic           is_div_q, neg_q_q, neg_r_q, dz_q;
    logic [31:0]    a_mag_q, b_mag_q;
    logic [63:0]    acc_q;

    logic           is_signed, fast_mul;
    logic [31:0]    mag_a, mag_b;
    logic [63:0]    init_acc, mul_step, div_step, fixed;
    logic [32:0]    madd, shifted, diff;

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign is_signed = ~Op[0];
    assign mag_a     = neg32(OpA, is_signed & OpA[31]);
    assign mag_b     = neg32(OpB, is_signed & OpB[31]);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{32{is_signed & OpA[31]}}, OpA};
    assign ext_b     = {{32{is_signed & OpB[31]}}, OpB};
    assign fast_prod = ext_a * ext_b;
    assign fast_mul  = ~Op[1];
    assign init_acc  = fast_mul ? fast_prod : {32'd0, mag_a};
`else
    assign fast_mul  = 1'b0;
    assign init_acc  = {32'd0, mag_a};
`endif

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
    assign madd     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
    assign mul_step = {madd, acc_q[31:1]};
    assign shifted  = {acc_q[63:32], acc_q[31]};
    assign diff     = shifted - {1'b0, b_mag_q};
    assign div_step = diff[32] ? {shifted[31:0], acc_q[30:0], 1'b0}
                               : {diff[31:0],    acc_q[30:0], 1'b1};

    always_comb begin
        fixed = neg64(acc_q, neg_q_q);
        if (is_div_q) begin
            if (dz_q)
                fixed = {neg32(a_mag_q, neg_r_q), 32'hFFFF_FFFF};
            else
                fixed = {neg32(acc_q[63:32], neg_r_q), neg32(acc_q[31:0], neg_q_q)};
        end
    end

    assign Busy  = (state_q != IDLE);
    assign Stall = Busy & (HiLoRead | Start | HiWrite | LoWrite);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = fast_mul ? FIX : RUN;
            RUN:     if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            FIX:     if (fix_ph_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            fix_ph_q  <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dz_q      <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    fix_ph_q <= fast_mul;
                    if (Start) begin
                        // a simultaneous mthi/mtlo is dropped; decode keeps them exclusive
                        is_div_q <= Op[1];
                        neg_q_q  <= is_signed & (OpA[31] ^ OpB[31]);
                        neg_r_q  <= is_signed & OpA[31];
                        dz_q     <= Op[1] & (OpB == 32'd0);
                        a_mag_q  <= mag_a;
                        b_mag_q  <= mag_b;
                        acc_q    <= init_acc;
                    end else begin
                        if (HiWrite) Hi <= WrData;
                        if (LoWrite) Lo <= WrData;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    acc_q <= is_div_q ? div_step : mul_step;
                end
                FIX: begin
                    if (!fix_ph_q) begin
                        fix_ph_q <= 1'b1;
                        acc_q    <= fixed;
                    end else begin
                        Hi        <= acc_q[63:32];
                        Lo        <= acc_q[31:0];
                        Done      <= 1'b1;
                        DivByZero <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
